// File: rtl/mq_pkg.sv
// ---------------------------------------------------------------------------
// mq_pkg
//   Shared types and constants for the MQ-coder byte-out stage.
//   - mq_state_t : codeword lifecycle (IDLE -> RUN -> FLUSH -> DRAIN -> IDLE)
//   - CT_STUFF / CT_NORM : CT reload values after a stuffed / normal byte
//   - BYTE_FF / BYTE_FE  : marker byte values used by the stuffing logic
// ---------------------------------------------------------------------------
package mq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DRAIN = 2'd3
  } mq_state_t;

  localparam logic [3:0] CT_STUFF = 4'd7;
  localparam logic [3:0] CT_NORM  = 4'd8;
  localparam logic [7:0] BYTE_FF  = 8'hFF;
  localparam logic [7:0] BYTE_FE  = 8'hFE;

endpackage

// File: rtl/mq_byte_fifo.sv
// ---------------------------------------------------------------------------
// mq_byte_fifo
//   Synchronous byte FIFO with an occupancy count and a registered head.
//   Storage is a plain array (RAM-inferable); the head register is loaded
//   with the entry that will be at the head after this cycle's pop, so
//   consecutive entries stream out with no bubble.
//
// Ports
//   clk        in   clock
//   rst        in   asynchronous active-low reset (empties the FIFO)
//   push       in   write push_data (ignored when full)
//   push_data  in   byte to write
//   pop        in   consume head (ignored when empty)
//   head_data  out  registered head byte
//   head_valid out  FIFO not empty
//   count      out  number of stored entries (0..DEPTH)
// ---------------------------------------------------------------------------
module mq_byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [7:0]               push_data,
  input  logic                     pop,
  output logic [7:0]               head_data,
  output logic                     head_valid,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW-1:0] rd_ptr_next;
  logic [AW:0]   count_reg;
  logic [AW:0]   count_next;
  logic [7:0]    head_reg;
  logic [7:0]    head_next;
  logic          do_push;
  logic          do_pop;

  always_comb begin
    do_push     = push && (count_reg != (AW+1)'(DEPTH));
    do_pop      = pop && (count_reg != '0);
    rd_ptr_next = rd_ptr_reg + AW'(do_pop);
    count_next  = count_reg + (AW+1)'(do_push) - (AW+1)'(do_pop);
    // When the FIFO is (or is about to become) empty, the byte written this
    // cycle becomes the new head; the array still holds stale data at that
    // address, so forward the write data straight into the head register.
    if (do_push && ((count_reg - (AW+1)'(do_pop)) == '0)) begin
      head_next = push_data;
    end else begin
      head_next = mem[rd_ptr_next];
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      head_reg   <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_reg + AW'(do_push);
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      head_reg   <= head_next;
    end
  end

  assign head_data  = head_reg;
  assign head_valid = (count_reg != '0);
  assign count      = count_reg;

endmodule

// File: rtl/mq_byte_out_buf.sv
// ---------------------------------------------------------------------------
// mq_byte_out_buf
//   MQ-coder byte-out stage. Holds the pending output byte B, applies the
//   BYTEOUT algorithm (carry into B, 0xFF bit stuffing, C masking and CT
//   reload) and queues committed bytes in a FIFO drained by a valid/ready
//   stream towards the codestream packer.
//
// Ports
//   clk          in   clock
//   rst          in   asynchronous active-low reset
//   enc_start    in   pulse in IDLE: start a codeword
//   bo_valid     in   byteout request from renormalisation
//   bo_ready     out  byteout accepted this cycle
//   c_in         in   C register at byteout time
//   c_out        out  masked C (combinational; c_in when no byteout active)
//   ct_out       out  CT reload value, 7 after a stuffed byte, else 8
//   flush_valid  in   end-of-codeword request
//   flush_ready  out  flush accepted this cycle
//   out_valid    out  FIFO head valid
//   out_ready    in   consumer takes the head
//   out_byte     out  FIFO head byte
//   byte_cnt     out  bytes pushed since enc_start (wraps)
//   b_ff / b_fe  out  pending B equals 0xFF / 0xFE
//   done         out  pulse: codeword flushed and FIFO drained
// ---------------------------------------------------------------------------
module mq_byte_out_buf
  import mq_pkg::*;
#(
  parameter int C_W           = 28,
  parameter int FIFO_DEPTH    = 8,
  parameter int CNT_W         = 16,
  parameter int DROP_TRAIL_FF = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enc_start,
  input  logic             bo_valid,
  output logic             bo_ready,
  input  logic [C_W-1:0]   c_in,
  output logic [C_W-1:0]   c_out,
  output logic [3:0]       ct_out,
  input  logic             flush_valid,
  output logic             flush_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_byte,
  output logic [CNT_W-1:0] byte_cnt,
  output logic             b_ff,
  output logic             b_fe,
  output logic             done
);

  localparam int FIFO_AW = $clog2(FIFO_DEPTH);

  mq_state_t        state_reg;
  mq_state_t        state_next;
  logic [7:0]       b_reg;
  logic             b_valid_reg;
  logic [CNT_W-1:0] byte_cnt_reg;

  logic [FIFO_AW:0] fifo_count;
  logic             fifo_push;
  logic [7:0]       fifo_push_data;

  logic             base_ready;
  logic             bo_fire;
  logic             flush_fire;
  logic             carry;
  logic [7:0]       b_inc;
  logic             stuff;
  logic [7:0]       b_new;
  logic             drop_trail;

  // -------------------------------------------------------------------------
  // Handshakes. A byteout always wins over a simultaneous flush, so the
  // flush is held off (flush_ready low) until the byteout has gone through.
  // -------------------------------------------------------------------------
  assign base_ready  = (state_reg == RUN) && (fifo_count < (FIFO_AW+1)'(FIFO_DEPTH));
  assign bo_ready    = base_ready;
  assign flush_ready = base_ready && !bo_valid;
  assign bo_fire     = bo_valid && base_ready;
  assign flush_fire  = flush_valid && flush_ready;

  assign b_ff = b_valid_reg && (b_reg == BYTE_FF);
  assign b_fe = b_valid_reg && (b_reg == BYTE_FE);

  // -------------------------------------------------------------------------
  // BYTEOUT datapath.
  // A stuff is needed when the byte being committed is (or becomes, through
  // the carry) 0xFF: the next byte then carries only 7 data bits.
  // -------------------------------------------------------------------------
  always_comb begin
    carry = c_in[C_W-1];
    b_inc = b_reg + 8'd1;
    stuff = b_ff || (carry && (b_inc == BYTE_FF));

    if (stuff) begin
      // Top bit of the 8-bit field is the carry; it has already been folded
      // into the committed byte, so it is cleared here.
      b_new = {c_in[C_W-1] & ~carry, c_in[C_W-2:C_W-8]};
    end else begin
      b_new = c_in[C_W-2:C_W-9];
    end

    c_out  = c_in;
    ct_out = CT_NORM;
    if (bo_valid && (state_reg == RUN)) begin
      if (stuff) begin
        c_out  = {{8{1'b0}}, c_in[C_W-9:0]};
        ct_out = CT_STUFF;
      end else begin
        c_out  = {{9{1'b0}}, c_in[C_W-10:0]};
        ct_out = CT_NORM;
      end
    end
  end

  // -------------------------------------------------------------------------
  // FIFO write side. The very first byteout of a codeword has no pending
  // byte to commit, so its carry has nowhere to go and is dropped.
  // -------------------------------------------------------------------------
  assign drop_trail = (DROP_TRAIL_FF != 0) && (b_reg == BYTE_FF);

  always_comb begin
    fifo_push      = 1'b0;
    fifo_push_data = b_reg;
    if (bo_fire) begin
      fifo_push      = b_valid_reg;
      fifo_push_data = carry ? b_inc : b_reg;
    end else if (flush_fire) begin
      fifo_push      = b_valid_reg && !drop_trail;
      fifo_push_data = b_reg;
    end
  end

  mq_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (fifo_push),
    .push_data  (fifo_push_data),
    .pop        (out_ready),
    .head_data  (out_byte),
    .head_valid (out_valid),
    .count      (fifo_count)
  );

  // -------------------------------------------------------------------------
  // Pending byte and committed-byte counter
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      b_reg        <= '0;
      b_valid_reg  <= 1'b0;
      byte_cnt_reg <= '0;
    end else if ((state_reg == IDLE) && enc_start) begin
      b_reg        <= '0;
      b_valid_reg  <= 1'b0;
      byte_cnt_reg <= '0;
    end else begin
      if (bo_fire) begin
        b_reg       <= b_new;
        b_valid_reg <= 1'b1;
      end else if (flush_fire) begin
        b_valid_reg <= 1'b0;
      end
      if (fifo_push) begin
        byte_cnt_reg <= byte_cnt_reg + CNT_W'(1);
      end
    end
  end

  assign byte_cnt = byte_cnt_reg;

  // -------------------------------------------------------------------------
  // Codeword FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (enc_start) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (flush_fire) begin
          state_next = FLUSH;
        end
      end
      FLUSH: begin
        state_next = DRAIN;
      end
      DRAIN: begin
        if (fifo_count == '0) begin
          done       = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mq_byte_out_buf.sv
module tb_mq_byte_out_buf;
  import mq_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        enc_start;
  logic        bo_valid;
  logic        bo_ready;
  logic [27:0] c_in;
  logic [27:0] c_out;
  logic [3:0]  ct_out;
  logic        flush_valid;
  logic        flush_ready;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_byte;
  logic [15:0] byte_cnt;
  logic        b_ff;
  logic        b_fe;
  logic        done;

  int compared   = 0;
  int mismatched = 0;
  int done_cnt   = 0;
  logic [7:0] sb [$];

  always #5 clk = ~clk;

  mq_byte_out_buf #(
    .C_W           (28),
    .FIFO_DEPTH    (4),
    .CNT_W         (16),
    .DROP_TRAIL_FF (1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enc_start   (enc_start),
    .bo_valid    (bo_valid),
    .bo_ready    (bo_ready),
    .c_in        (c_in),
    .c_out       (c_out),
    .ct_out      (ct_out),
    .flush_valid (flush_valid),
    .flush_ready (flush_ready),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_byte    (out_byte),
    .byte_cnt    (byte_cnt),
    .b_ff        (b_ff),
    .b_fe        (b_fe),
    .done        (done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  // Monitor: inputs only change just after posedge, so at negedge the values
  // seen are those the next posedge will act on.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL fifo_pop_unexpected: got 0x%0h required no byte", out_byte);
      end else begin
        logic [7:0] exp_b;
        exp_b = sb.pop_front();
        check("fifo_byte", {24'h0, out_byte}, {24'h0, exp_b});
      end
    end
    if (done) done_cnt++;
  end

  task automatic start_cw();
    @(negedge clk);
    enc_start = 1'b1;
    @(posedge clk);
    #1 enc_start = 1'b0;
    check("start_byte_cnt", {16'h0, byte_cnt}, 32'd0);
    check("start_bo_ready", {31'h0, bo_ready}, 32'd1);
  endtask

  task automatic byteout(input logic [27:0] c, input logic [3:0] ect, input logic [27:0] ecout,
                         input bit exp_push, input logic [7:0] pb,
                         input bit eff, input bit efe, input int ecnt);
    int n;
    @(negedge clk);
    c_in     = c;
    bo_valid = 1'b1;
    #1;
    n = 0;
    while (!bo_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("bo_ready", {31'h0, bo_ready}, 32'd1);
    check("ct_out", {28'h0, ct_out}, {28'h0, ect});
    check("c_out", {4'h0, c_out}, {4'h0, ecout});
    @(posedge clk);
    if (exp_push) sb.push_back(pb);
    #1 bo_valid = 1'b0;
    check("b_ff", {31'h0, b_ff}, {31'h0, eff});
    check("b_fe", {31'h0, b_fe}, {31'h0, efe});
    check("byte_cnt", {16'h0, byte_cnt}, ecnt);
  endtask

  task automatic flush_cw(input bit exp_push, input logic [7:0] pb, input int ecnt);
    int n;
    int d0;
    @(negedge clk);
    flush_valid = 1'b1;
    #1;
    n = 0;
    while (!flush_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("flush_ready", {31'h0, flush_ready}, 32'd1);
    d0 = done_cnt;
    @(posedge clk);
    if (exp_push) sb.push_back(pb);
    #1 flush_valid = 1'b0;
    check("flush_byte_cnt", {16'h0, byte_cnt}, ecnt);
    n = 0;
    while (done_cnt == d0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    check("done_pulses", done_cnt - d0, 32'd1);
    check("state_idle", {30'h0, dut.state_reg}, {30'h0, IDLE});
    check("idle_bo_ready", {31'h0, bo_ready}, 32'd0);
  endtask

  initial begin
    rst = 1'b0; enc_start = 1'b0; bo_valid = 1'b0; flush_valid = 1'b0;
    out_ready = 1'b0; c_in = 28'h1234567;
    #12;
    check("rst_out_valid", {31'h0, out_valid}, 32'd0);
    check("rst_byte_cnt", {16'h0, byte_cnt}, 32'd0);
    check("rst_bo_ready", {31'h0, bo_ready}, 32'd0);
    check("rst_flush_ready", {31'h0, flush_ready}, 32'd0);
    check("rst_b_ff_fe", {30'h0, b_ff, b_fe}, 32'd0);
    check("rst_done", {31'h0, done}, 32'd0);
    check("rst_ct_out", {28'h0, ct_out}, 32'd8);
    check("rst_c_out", {4'h0, c_out}, 32'h1234567);
    check("rst_state", {30'h0, dut.state_reg}, {30'h0, IDLE});
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b1;

    // Codeword 1: carry, stuffing and trailing-0xFF drop
    start_cw();
    byteout(28'h0A80000, 4'd8, 28'h0,       1'b0, 8'h00, 1'b0, 1'b0, 0);
    byteout(28'h9000000, 4'd8, 28'h0,       1'b1, 8'h16, 1'b0, 1'b0, 1);
    byteout(28'h7F80000, 4'd8, 28'h0,       1'b1, 8'h20, 1'b1, 1'b0, 2);
    byteout(28'h5300000, 4'd7, 28'h0,       1'b1, 8'hFF, 1'b0, 1'b0, 3);
    byteout(28'h7F00000, 4'd8, 28'h0,       1'b1, 8'h53, 1'b0, 1'b1, 4);
    byteout(28'h8A00000, 4'd7, 28'h0,       1'b1, 8'hFF, 1'b0, 1'b0, 5);
    byteout(28'h8100005, 4'd8, 28'h0000005, 1'b1, 8'h0B, 1'b0, 1'b0, 6);
    byteout(28'h7F80000, 4'd8, 28'h0,       1'b1, 8'h02, 1'b1, 1'b0, 7);
    byteout(28'h12ABCDE, 4'd7, 28'h00ABCDE, 1'b1, 8'hFF, 1'b0, 1'b0, 8);
    byteout(28'h7F80000, 4'd8, 28'h0,       1'b1, 8'h12, 1'b1, 1'b0, 9);
    flush_cw(1'b0, 8'h00, 9);

    // Codeword 2: fill the 4-entry FIFO with the consumer stalled
    @(posedge clk);
    #1 out_ready = 1'b0;
    start_cw();
    byteout(28'h0880000, 4'd8, 28'h0, 1'b0, 8'h00, 1'b0, 1'b0, 0);
    byteout(28'h1100000, 4'd8, 28'h0, 1'b1, 8'h11, 1'b0, 1'b0, 1);
    byteout(28'h1980000, 4'd8, 28'h0, 1'b1, 8'h22, 1'b0, 1'b0, 2);
    byteout(28'h2200000, 4'd8, 28'h0, 1'b1, 8'h33, 1'b0, 1'b0, 3);
    byteout(28'h2A80000, 4'd8, 28'h0, 1'b1, 8'h44, 1'b0, 1'b0, 4);
    check("full_bo_ready", {31'h0, bo_ready}, 32'd0);
    check("full_head", {24'h0, out_byte}, 32'h11);
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    #1 check("after_pop_bo_ready", {31'h0, bo_ready}, 32'd1);
    flush_cw(1'b1, 8'h55, 5);

    // Codeword 3: asynchronous reset with bytes queued
    @(posedge clk);
    #1 out_ready = 1'b0;
    start_cw();
    byteout(28'h3080000, 4'd8, 28'h0, 1'b0, 8'h00, 1'b0, 1'b0, 0);
    byteout(28'h3100000, 4'd8, 28'h0, 1'b0, 8'h00, 1'b0, 1'b0, 1);
    byteout(28'h3180000, 4'd8, 28'h0, 1'b0, 8'h00, 1'b0, 1'b0, 2);
    byteout(28'h3200000, 4'd8, 28'h0, 1'b0, 8'h00, 1'b0, 1'b0, 3);
    check("queued_out_valid", {31'h0, out_valid}, 32'd1);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("arst_out_valid", {31'h0, out_valid}, 32'd0);
    check("arst_byte_cnt", {16'h0, byte_cnt}, 32'd0);
    check("arst_state", {30'h0, dut.state_reg}, {30'h0, IDLE});
    check("arst_b_ff", {31'h0, b_ff}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
